// File: rtl/gsm_cmd_issuer_if.sv
// Handshake bundle between the event sources / game-flow FSM and the gsm,
// as seen through the command issuer.
interface gsm_cmd_issuer_if;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;
  logic       done;
  logic [3:0] flag;
  logic       trig;
  logic       busy;
  logic       err_timeout;
  logic       hit_ovf;

  modport master (
    input  hit_pulse, miss_pulse, cmd_valid, cmd_code, done,
    output cmd_ready, flag, trig, busy, err_timeout, hit_ovf
  );

  modport slave (
    output hit_pulse, miss_pulse, cmd_valid, cmd_code, done,
    input  cmd_ready, flag, trig, busy, err_timeout, hit_ovf
  );
endinterface

// File: rtl/gsm_cmd_issuer.sv
// Serialises hit/miss pulses and game-flow commands into single gsm
// flag/trig/done transactions, with pending storage and a done timeout.
module gsm_cmd_issuer #(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int HIT_CNT_W      = 4
) (
  input logic              clk_1mhz,
  input logic              rst,
  gsm_cmd_issuer_if.master bus
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       FLAG_MISS = 4'b0010;
  localparam logic [3:0]       FLAG_HIT  = 4'b0001;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_t;
  typedef enum logic [1:0] {SRC_MISS, SRC_HIT, SRC_CMD} src_t;

  function automatic logic is_legal_code(input logic [3:0] code);
    case (code)
      4'b0100, 4'b0101, 4'b1000, 4'b1010,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: is_legal_code = 1'b1;
      default:                            is_legal_code = 1'b0;
    endcase
  endfunction

  // Codes after which the gsm resets score and lives.
  function automatic logic is_flush_code(input logic [3:0] code);
    is_flush_code = (code == 4'b1000) || (code == 4'b1111);
  endfunction

  state_t               state, state_nxt;
  src_t                 src_q, src_nxt;
  logic [3:0]           flag_q, flag_nxt;
  logic                 trig_q, trig_nxt;
  logic                 err_q, err_nxt;
  logic [TMO_W-1:0]     tmo_cnt, tmo_nxt;
  logic [GAP_W-1:0]     gap_cnt, gap_nxt;
  logic                 consume;

  logic [HIT_CNT_W-1:0] hit_pend;
  logic [1:0]           miss_pend;
  logic                 hit_ovf_q;
  logic                 slot_full;
  logic [3:0]           slot_code;

  logic cmd_accept, miss_avail, hit_avail, cmd_avail;
  logic hit_inc, hit_dec, miss_inc, miss_dec, flush, cmd_done;

  assign cmd_accept = bus.cmd_valid && !slot_full && is_legal_code(bus.cmd_code);
  // Incoming events count as available so trig rises on the edge that captures them.
  assign miss_avail = (miss_pend != 2'd0) || bus.miss_pulse;
  assign hit_avail  = (hit_pend != '0) || bus.hit_pulse;
  assign cmd_avail  = slot_full || cmd_accept;

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    flag_nxt  = flag_q;
    trig_nxt  = trig_q;
    err_nxt   = 1'b0;
    tmo_nxt   = tmo_cnt;
    gap_nxt   = gap_cnt;
    consume   = 1'b0;
    case (state)
      S_IDLE: begin
        tmo_nxt = '0;
        gap_nxt = '0;
        if (miss_avail) begin
          flag_nxt  = FLAG_MISS;
          src_nxt   = SRC_MISS;
          trig_nxt  = 1'b1;
          state_nxt = S_WAIT_DONE;
        end else if (hit_avail) begin
          flag_nxt  = FLAG_HIT;
          src_nxt   = SRC_HIT;
          trig_nxt  = 1'b1;
          state_nxt = S_WAIT_DONE;
        end else if (cmd_avail) begin
          flag_nxt  = slot_full ? slot_code : bus.cmd_code;
          src_nxt   = SRC_CMD;
          trig_nxt  = 1'b1;
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        tmo_nxt = tmo_cnt + TMO_W'(1);
        if (bus.done || (tmo_cnt == TMO_LAST)) begin
          err_nxt   = !bus.done;
          consume   = 1'b1;
          trig_nxt  = 1'b0;
          gap_nxt   = '0;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        gap_nxt = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      state   <= S_IDLE;
      src_q   <= SRC_MISS;
      flag_q  <= 4'b0000;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      src_q   <= src_nxt;
      flag_q  <= flag_nxt;
      trig_q  <= trig_nxt;
      err_q   <= err_nxt;
      tmo_cnt <= tmo_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  assign hit_inc  = bus.hit_pulse;
  assign hit_dec  = consume && (src_q == SRC_HIT);
  assign miss_inc = bus.miss_pulse;
  assign miss_dec = consume && (src_q == SRC_MISS);
  assign cmd_done = consume && (src_q == SRC_CMD);
  assign flush    = cmd_done && is_flush_code(flag_q);

  // Pending work; a pulse landing on the flush edge is newer than the flush and survives.
  always_ff @(posedge clk_1mhz) begin
    if (rst) begin
      hit_pend  <= '0;
      miss_pend <= 2'd0;
      hit_ovf_q <= 1'b0;
      slot_full <= 1'b0;
    end else begin
      if (flush)
        hit_pend <= HIT_CNT_W'(bus.hit_pulse);
      else if (hit_inc && !hit_dec && (hit_pend != '1))
        hit_pend <= hit_pend + HIT_CNT_W'(1);
      else if (hit_dec && !hit_inc)
        hit_pend <= hit_pend - HIT_CNT_W'(1);

      if (hit_inc && !hit_dec && !flush && (hit_pend == '1))
        hit_ovf_q <= 1'b1;

      if (flush)
        miss_pend <= {1'b0, bus.miss_pulse};
      else if (miss_inc && !miss_dec && (miss_pend != 2'd3))
        miss_pend <= miss_pend + 2'd1;
      else if (miss_dec && !miss_inc)
        miss_pend <= miss_pend - 2'd1;

      if (cmd_accept)
        slot_full <= 1'b1;
      else if (cmd_done)
        slot_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_1mhz) begin
    if (cmd_accept) slot_code <= bus.cmd_code;
  end

  assign bus.cmd_ready   = !slot_full;
  assign bus.flag        = flag_q;
  assign bus.trig        = trig_q;
  assign bus.err_timeout = err_q;
  assign bus.hit_ovf     = hit_ovf_q;
  assign bus.busy        = (state != S_IDLE) || (hit_pend != '0) ||
                           (miss_pend != 2'd0) || slot_full;
endmodule

// File: tb/tb_gsm_cmd_issuer.sv
// Bench for gsm_cmd_issuer: a small gsm model answers each trig with done and
// records issued flags, which are scored against an expected-flag queue.
`timescale 1ns/1ps
module tb_gsm_cmd_issuer;
  logic clk;
  logic rst;
  gsm_cmd_issuer_if bus ();

  gsm_cmd_issuer #(.GAP_CYCLES(4), .TIMEOUT_CYCLES(64), .HIT_CNT_W(4)) dut (
    .clk_1mhz (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  int         rise_cnt = 0;
  int         score = 0;
  bit         gsm_en = 1'b1;
  int         gsm_lat = 3;

  // gsm model: logs every trig rising edge and answers with done after gsm_lat cycles.
  initial begin
    bit trig_prev;
    int done_cd;
    trig_prev = 1'b0;
    done_cd   = 0;
    bus.done  = 1'b0;
    forever begin
      @(negedge clk);
      bus.done = 1'b0;
      if (rst) begin
        trig_prev = 1'b0;
        done_cd   = 0;
      end else begin
        if (done_cd != 0) begin
          done_cd--;
          if (done_cd == 0) bus.done = 1'b1;
        end
        if (bus.trig && !trig_prev) begin
          obs_q.push_back(bus.flag);
          rise_cnt++;
          if (bus.flag == 4'b0001) score++;
          if (gsm_en) done_cd = gsm_lat;
        end
        trig_prev = bus.trig;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++; if (bus.flag !== 4'b0000) begin errors++; $display("FAIL reset_flag got=%b exp=0000", bus.flag); end
    checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL reset_trig got=%b exp=0", bus.trig); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_timeout); end
    checks++; if (bus.hit_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.hit_ovf); end
  endtask

  task automatic test_single_hit();
    tick(7);
    exp_q.push_back(4'b0001);
    bus.hit_pulse = 1'b1;
    tick(1);
    bus.hit_pulse = 1'b0;
    checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL single_trig_rise got=%b exp=1", bus.trig); end
    checks++; if (bus.flag !== 4'b0001) begin errors++; $display("FAIL single_flag got=%b exp=0001", bus.flag); end
    tick(3);
    checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL single_trig_hold got=%b exp=1", bus.trig); end
    tick(1);
    checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL single_trig_drop got=%b exp=0", bus.trig); end
    tick(3);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_gap_busy got=%b exp=1", bus.busy); end
    tick(1);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", bus.busy); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL single_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL single_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_burst();
    int base_rise, base_score;
    bit ok;
    base_rise  = rise_cnt;
    base_score = score;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'b0001);
      bus.hit_pulse = 1'b1;
      tick(1);
    end
    bus.hit_pulse = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_idle got=busy exp=idle"); end
    checks++; if (rise_cnt - base_rise != 5) begin errors++; $display("FAIL burst_rises got=%0d exp=5", rise_cnt - base_rise); end
    checks++; if (score - base_score != 5) begin errors++; $display("FAIL burst_score got=%0d exp=5", score - base_score); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL burst_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL burst_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_priority();
    int  base_rise;
    bit  early_ready;
    bit  ok;
    base_rise   = rise_cnt;
    early_ready = 1'b0;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1100);
    bus.hit_pulse  = 1'b1;
    bus.miss_pulse = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_code   = 4'b1100;
    tick(1);
    bus.hit_pulse  = 1'b0;
    bus.miss_pulse = 1'b0;
    bus.cmd_valid  = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL prio_ready_low got=%b exp=0", bus.cmd_ready); end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (bus.cmd_ready && (rise_cnt - base_rise < 3)) early_ready = 1'b1;
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL prio_idle got=busy exp=idle"); end
    checks++; if (early_ready) begin errors++; $display("FAIL prio_ready_early got=1 exp=0"); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL prio_ready_end got=%b exp=1", bus.cmd_ready); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL prio_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL prio_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_flush();
    bit ok;
    exp_q.push_back(4'b0010);
    repeat (3) exp_q.push_back(4'b0001);
    exp_q.push_back(4'b1000);
    bus.miss_pulse = 1'b1;
    bus.hit_pulse  = 1'b1;
    tick(1);
    bus.miss_pulse = 1'b0;
    tick(2);
    bus.hit_pulse  = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_code   = 4'b1000;
    tick(1);
    bus.cmd_valid  = 1'b0;
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_idle got=busy exp=idle"); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL flush_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL flush_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_flush_live_hits();
    int base_rise;
    bit ok;
    base_rise = rise_cnt;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 4'b1000;
    tick(1);
    bus.cmd_valid = 1'b0;
    bus.hit_pulse = 1'b1;
    tick(2);
    bus.hit_pulse = 1'b0;
    tick(4);
    bus.hit_pulse = 1'b1;
    tick(2);
    bus.hit_pulse = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush2_idle got=busy exp=idle"); end
    checks++; if (rise_cnt - base_rise != 3) begin errors++; $display("FAIL flush2_rises got=%0d exp=3", rise_cnt - base_rise); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL flush2_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL flush2_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_timeout();
    int trig_cycles, err_cycles;
    bit ok;
    gsm_en      = 1'b0;
    trig_cycles = 0;
    err_cycles  = 0;
    ok          = 1'b0;
    exp_q.push_back(4'b0001);
    bus.hit_pulse = 1'b1;
    tick(1);
    bus.hit_pulse = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (bus.trig) trig_cycles++;
      if (bus.err_timeout) err_cycles++;
      if (!bus.busy) begin ok = 1'b1; break; end
      tick(1);
    end
    gsm_en = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL tmo_idle got=busy exp=idle"); end
    checks++; if (trig_cycles != 64) begin errors++; $display("FAIL tmo_trig_len got=%0d exp=64", trig_cycles); end
    checks++; if (err_cycles != 1) begin errors++; $display("FAIL tmo_err_pulses got=%0d exp=1", err_cycles); end
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL tmo_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL tmo_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  task automatic test_saturation_reset();
    int base_rise;
    gsm_en = 1'b0;
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 17; i++) begin
      bus.hit_pulse = 1'b1;
      tick(1);
    end
    bus.hit_pulse = 1'b0;
    checks++; if (bus.hit_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", bus.hit_ovf); end
    checks++; if (dut.hit_pend !== 4'd15) begin errors++; $display("FAIL sat_pend got=%0d exp=15", dut.hit_pend); end
    checks++; if (bus.trig !== 1'b1) begin errors++; $display("FAIL sat_trig got=%b exp=1", bus.trig); end
    rst = 1'b1;
    tick(1);
    checks++; if (bus.trig !== 1'b0) begin errors++; $display("FAIL rst_trig got=%b exp=0", bus.trig); end
    checks++; if (bus.hit_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", bus.hit_ovf); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    base_rise = rise_cnt;
    tick(100);
    checks++; if (rise_cnt != base_rise) begin errors++; $display("FAIL rst_no_trig got=%0d exp=0", rise_cnt - base_rise); end
    gsm_en = 1'b1;
    while (exp_q.size() > 0) begin
      logic [3:0] e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL sat_sb got=none exp=%b", e); end
      else begin
        logic [3:0] o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL sat_sb got=%b exp=%b", o, e); end
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.hit_pulse  = 1'b0;
    bus.miss_pulse = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_code   = 4'b0000;
    tick(1);
    test_reset();
    test_single_hit();
    test_burst();
    test_priority();
    test_flush();
    test_flush_live_hits();
    test_timeout();
    test_saturation_reset();
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL unexpected_cmds got=%0d exp=0", obs_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
